uart_frame_tx: RTL
==================

# uart_frame_tx

UART transmitter that streams the LED panel's 16×8 frame buffer and current colour back to the host, forming the return direction of the panel's serial link. On a start pulse it sends a fixed packet and reads frame bytes through a synchronous address / combinational data port. The packet is a sync byte, a colour/control byte, then 16 frame bytes, with an optional checksum. It sits beside the panel driver and shares its clock, reset, baud constant and 0xF5 sync convention.

## Interface
- CLKS_PER_BIT, 20, clk cycles per UART bit (≥2)
- SYNC_BYTE, 8'hF5, first byte of every packet
- clk  in  1  single system clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to send a packet; ignored while busy
- rgb  in  3  current colour, sampled on accepted start
- fb_addr  out  4  frame buffer read address (registered)
- fb_data  in  8  frame buffer column at fb_addr, combinational
- tx_serial  out  1  UART line, 8N1, LSB first, idle high
- busy  out  1  high while a packet is in progress
- done  out  1  one-cycle pulse when the packet finishes

## Operation
- Reset values (immediate, async):
  - tx_serial=1, busy=0, done=0, fb_addr=0.
  - Internal state IDLE, byte_idx=0, bit counters 0, checksum 0.
- Packet order by byte_idx:
  - 0: SYNC_BYTE.
  - 1: {5'b0, rgb_snapshot}.
  - 2..17: fb_data for fb_addr 0..15.
  - 18: checksum, only with the macro enabled.
- Bit serializer states:
  - IDLE → START (line low) → DATA (8 bits, LSB first) → STOP (line high).
  - From STOP: go to START of the next byte, or to IDLE after the last byte.
- Each state lasts exactly CLKS_PER_BIT cycles. A per-bit counter counts 0..CLKS_PER_BIT-1 and a bit index counts 0..7.
- Accepted start in IDLE:
  - Snapshot rgb, set busy, set byte_idx=0, clear checksum, load SYNC_BYTE into the shift register.
- Frame reads:
  - fb_addr = byte_idx-2 for the byte about to be loaded.
  - fb_addr is updated on the first cycle of the preceding byte's STOP.
  - fb_data is sampled on the last cycle of that STOP.
- Frame bytes are read live, with no frame snapshot. A buffer write during a packet is reflected in any column not yet loaded.
- start while busy is ignored and not queued. start on the same cycle done pulses is ignored.

## Timing
- tx_serial falls on the clock edge after start is accepted. busy rises on that same edge.
- Byte period is 10·CLKS_PER_BIT cycles. Bytes are back-to-back, with no idle gap between a STOP and the next START.
- Packet length is 18 bytes without the checksum (3600 cycles at default) and 19 bytes with it (3800 cycles).
- After the final STOP completes:
  - done=1 for one cycle.
  - busy falls on that same edge.
  - The earliest next accepted start is the following cycle.
- Reset mid-packet:
  - The line returns high immediately and the packet is abandoned.
  - No done pulse.
  - The next packet restarts from byte 0.

## Configuration
- UART_FRAME_TX_CHECKSUM_EN defined:
  - Byte 18 = XOR of bytes 0..17, running XOR updated as each byte is loaded.
  - done follows byte 18.
- Not defined: packet ends after byte 17, with no checksum register or logic.

## Structure
- Shared package uart_pkg holds:
  - the default CLKS_PER_BIT (20) and SYNC_BYTE (8'hF5);
  - the serializer state enum (IDLE, START, DATA, STOP);
  - packet constants FRAME_BYTES=16 and HDR_BYTES=2.
- One sub-module, uart_tx_byte:
  - Bit serializer with ports data[7:0], load, tx_serial, byte_done (one-cycle pulse on the last STOP cycle).
  - The top level is the byte sequencer, checksum logic and fb_addr generator around it.

## Test plan
- Reset state, then idle: tx_serial=1, busy=0, done=0, fb_addr=0, with no line activity for 1000 cycles.
- Default reset frame, rgb=3'b101, start pulse: decoded bytes are F5, 05, then the 16 buffer columns in address order. With the checksum macro, the last byte equals the XOR of all prior bytes (F5^05=F0 for an all-zero buffer). done arrives exactly 3800 cycles after start (3600 without the macro).
- Bit timing: every bit lasts 20 cycles. The start bit follows the accepted start by 1 cycle, and there are 0 idle cycles between a stop bit and the next start bit.
- start pulses at +5, +1000 and on the done cycle: exactly one packet is sent and no second packet starts.
- Reset asserted at cycle 1500: tx_serial=1 and busy=0 immediately, no done pulse. A new start then yields a complete packet beginning with F5.
- Write 8'hAA to column 15 while column 3 is on the line: byte 17 = AA. Write column 0 at the same moment: byte 2 keeps its old value.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and serializer state encoding for the panel's UART return link.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 20;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hF5;

  localparam int FRAME_BYTES = 16;
  localparam int HDR_BYTES = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 bit serializer: START, eight LSB-first DATA bits, STOP, each CLKS_PER_BIT cycles long.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx_serial,
  output logic       byte_done,
  output logic       stop_next
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          cntLast;

  // Status pulses are kept out of the next-state block so the sequencer's
  // load, which depends on them, never forms a loop through this module.
  assign cntLast   = (cnt_q == CNT_LAST);
  assign byte_done = (state_q == STOP) && cntLast;
  assign stop_next = (state_q == DATA) && cntLast && (bit_q == 3'd7);
  assign tx_serial = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = START;
          cnt_d   = '0;
          shift_d = data;
        end
      end
      START: begin
        if (cntLast) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cntLast) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cntLast) begin
          cnt_d = '0;
          if (load) begin
            state_d = START;
            shift_d = data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered from the next state so it changes exactly on the bit edge.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Packet sequencer streaming sync, colour and 16 live frame columns over UART.
// Define UART_FRAME_TX_CHECKSUM_EN to append an XOR checksum byte.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] rgb,
  output logic [3:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic       tx_serial,
  output logic       busy,
  output logic       done
);

`ifdef UART_FRAME_TX_CHECKSUM_EN
  localparam int LAST_IDX = HDR_BYTES + FRAME_BYTES;
`else
  localparam int LAST_IDX = HDR_BYTES + FRAME_BYTES - 1;
`endif

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [4:0] byteIdx_q, byteIdx_d;
  logic [2:0] rgb_q, rgb_d;
  logic [3:0] fbAddr_q, fbAddr_d;
`ifdef UART_FRAME_TX_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  logic       accept;
  logic       load;
  logic [7:0] loadData;
  logic [7:0] nextData;
  logic [4:0] nextIdx;
  logic       byteDone;
  logic       stopNext;
  logic       lastByte;
  logic       frameNext;

  assign fb_addr = fbAddr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // A start landing on the done cycle is dropped so back-to-back requests need a fresh pulse.
  assign accept    = start && !busy_q && !done_q;
  assign nextIdx   = byteIdx_q + 5'd1;
  assign lastByte  = (byteIdx_q == 5'(LAST_IDX));
  assign frameNext = (byteIdx_q >= 5'(HDR_BYTES - 1)) &&
                     (byteIdx_q <= 5'(HDR_BYTES + FRAME_BYTES - 2));

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .data     (loadData),
    .load     (load),
    .tx_serial(tx_serial),
    .byte_done(byteDone),
    .stop_next(stopNext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      byteIdx_q <= '0;
      rgb_q     <= '0;
      fbAddr_q  <= '0;
`ifdef UART_FRAME_TX_CHECKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      byteIdx_q <= byteIdx_d;
      rgb_q     <= rgb_d;
      fbAddr_q  <= fbAddr_d;
`ifdef UART_FRAME_TX_CHECKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  always_comb begin
    nextData = fb_data;
    if (nextIdx == 5'd1) begin
      nextData = {5'b0, rgb_q};
    end
`ifdef UART_FRAME_TX_CHECKSUM_EN
    else if (nextIdx == 5'(LAST_IDX)) begin
      nextData = chk_q;
    end
`endif
  end

  // Frame columns are read live: fb_addr moves when the previous byte enters
  // STOP and fb_data is taken on that STOP's last cycle.
  always_comb begin
    busy_d    = busy_q;
    done_d    = 1'b0;
    byteIdx_d = byteIdx_q;
    rgb_d     = rgb_q;
    fbAddr_d  = fbAddr_q;
    load      = 1'b0;
    loadData  = nextData;
`ifdef UART_FRAME_TX_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    if (accept) begin
      busy_d    = 1'b1;
      byteIdx_d = '0;
      rgb_d     = rgb;
      load      = 1'b1;
      loadData  = SYNC_BYTE;
`ifdef UART_FRAME_TX_CHECKSUM_EN
      chk_d     = SYNC_BYTE;
`endif
    end else if (busy_q && byteDone) begin
      if (lastByte) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        byteIdx_d = nextIdx;
        load      = 1'b1;
`ifdef UART_FRAME_TX_CHECKSUM_EN
        chk_d     = chk_q ^ nextData;
`endif
      end
    end
    if (busy_q && stopNext && frameNext) begin
      fbAddr_d = 4'(byteIdx_q - 5'd1);
    end
  end

endmodule
